// File: rtl/dm_cmd_pkg.sv
// Shared types and constants for the DM abstract-command / resume controller.
package dm_cmd_pkg;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4,
        CMDERR_OTHER      = 3'd7
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GO     = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    localparam logic [7:0] CmdTypeAccessReg = 8'h00;
    localparam int unsigned FlagGoBit     = 0;
    localparam int unsigned FlagResumeBit = 1;
    localparam int unsigned PostexecBit   = 18;
    localparam int unsigned TransferBit   = 17;

    function automatic logic [7:0] cmd_type(input logic [31:0] cmd);
        return cmd[31:24];
    endfunction

    // A command only needs the hart when it transfers or runs the program buffer.
    function automatic logic cmd_needs_hart(input logic [31:0] cmd);
        return cmd[TransferBit] | cmd[PostexecBit];
    endfunction

endpackage

// File: rtl/dm_cmd_ctrl_timeout_cnt.sv
// Saturating watchdog counter; expired_o flags the edge on which Limit is reached.
module dm_timeout_cnt #(
    parameter int unsigned Limit    = 1024,
    parameter int unsigned CntWidth = $clog2(Limit + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CntWidth-1:0] LimitC = CntWidth'(Limit);
    localparam logic [CntWidth-1:0] LastC  = CntWidth'(Limit - 1);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LimitC)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // Reported one cycle early so the abort lands on the same edge the count hits Limit.
    assign expired_o = en_i && !clr_i && (cnt_q >= LastC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dm_cmd_ctrl.sv
// Issuing side of the go/resume flag handshake: latches abstract commands and
// resume requests, drives the hart-polled flags word and reports busy/cmderr/resumeack.
module dm_cmd_ctrl
    import dm_cmd_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_i,
    input  logic        cmderr_clear_i,
    input  logic        resumereq_i,
    input  logic        halted_i,
    input  logic        resuming_i,
    input  logic        hart_going_i,
    input  logic        hart_halted_ack_i,
    input  logic        hart_exception_i,
    output logic [63:0] flags_o,
    output logic [31:0] cmd_q_o,
    output logic        busy_o,
    output logic [2:0]  cmderr_o,
    output logic        resumeack_o
);

    localparam logic [1:0] StIdle   = ST_IDLE;
    localparam logic [1:0] StGo     = ST_GO;
    localparam logic [1:0] StExec   = ST_EXEC;
    localparam logic [1:0] StResume = ST_RESUME;

    logic [1:0]  state_d, state_q;
    logic [63:0] flags_d, flags_q;
    logic [31:0] cmd_d, cmd_q;
    logic        busy_d, busy_q;
    logic [2:0]  cmderr_d, cmderr_q;
    logic        resumeack_d, resumeack_q;

    logic        err_set;
    logic [2:0]  err_val;
    logic        cnt_clr, cnt_en, expired;

    assign cnt_en = (state_q == StGo) || (state_q == StExec);

    dm_timeout_cnt #(
        .Limit    (TimeoutCycles),
        .CntWidth (CntWidth)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        cmd_d       = cmd_q;
        busy_d      = 1'b0;
        resumeack_d = resumeack_q;
        err_set     = 1'b0;
        err_val     = cmderr_q;
        cnt_clr     = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    // busy_q here is the one-cycle pulse of a no-hart command.
                    if (busy_q) begin
                        if (cmderr_q == CMDERR_NONE) begin
                            err_set = 1'b1;
                            err_val = CMDERR_BUSY;
                        end
                    end else if (cmderr_q != CMDERR_NONE) begin
                        err_set = 1'b0;
                    end else if (cmd_type(cmd_i) != CmdTypeAccessReg) begin
                        err_set = 1'b1;
                        err_val = CMDERR_NOTSUP;
                    end else if (!halted_i) begin
                        err_set = 1'b1;
                        err_val = CMDERR_HALTRESUME;
                    end else begin
                        cmd_d  = cmd_i;
                        busy_d = 1'b1;
                        if (cmd_needs_hart(cmd_i)) begin
                            flags_d[FlagGoBit] = 1'b1;
                            state_d            = StGo;
                            cnt_clr            = 1'b1;
                        end
                    end
                end else if (resumereq_i && halted_i && !busy_q) begin
                    flags_d[FlagResumeBit] = 1'b1;
                    resumeack_d            = 1'b0;
                    state_d                = StResume;
                end
            end

            StGo, StExec: begin
                busy_d = 1'b1;
                if (cmd_valid_i && (cmderr_q == CMDERR_NONE)) begin
                    err_set = 1'b1;
                    err_val = CMDERR_BUSY;
                end
                if (state_q == StExec && hart_exception_i) begin
                    err_set = 1'b1;
                    err_val = CMDERR_EXCEPT;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (state_q == StExec && hart_halted_ack_i) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (expired) begin
                    err_set = 1'b1;
                    err_val = CMDERR_OTHER;
                    flags_d = '0;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (state_q == StGo && hart_going_i) begin
                    flags_d[FlagGoBit] = 1'b0;
                    state_d            = StExec;
                end
            end

            StResume: begin
                if (cmd_valid_i && (cmderr_q == CMDERR_NONE)) begin
                    err_set = 1'b1;
                    err_val = CMDERR_BUSY;
                end
                if (resuming_i) begin
                    flags_d[FlagResumeBit] = 1'b0;
                    resumeack_d            = 1'b1;
                    state_d                = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase

        // The W1C from the DMI side outranks any error raised in the same cycle.
        if (cmderr_clear_i) begin
            cmderr_d = CMDERR_NONE;
        end else if (err_set) begin
            cmderr_d = err_val;
        end else begin
            cmderr_d = cmderr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            flags_q     <= '0;
            cmd_q       <= '0;
            busy_q      <= 1'b0;
            cmderr_q    <= CMDERR_NONE;
            resumeack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cmd_q       <= cmd_d;
            busy_q      <= busy_d;
            cmderr_q    <= cmderr_d;
            resumeack_q <= resumeack_d;
        end
    end

    assign flags_o     = flags_q;
    assign cmd_q_o     = cmd_q;
    assign busy_o      = busy_q;
    assign cmderr_o    = cmderr_q;
    assign resumeack_o = resumeack_q;

endmodule
